// File: rtl/ttl_priority_decoder_latch.sv
// Registered 3-to-8 decoder / addressable latch, the receiving end of a 74148 priority encoder.
// Define TTL_DECODER_GLITCH_FILTER_EN to require two matching mode-11 samples before Q updates.
module ttl_priority_decoder_latch #(
    parameter int WIDTH_OUT  = 8,
    parameter int WIDTH_IN   = 3,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic                 Clk,
    input  logic                 Clear_bar,
    input  logic                 EI_bar,
    input  logic [1:0]           Mode,
    input  logic [WIDTH_IN-1:0]  Y_bar,
    input  logic                 GS_bar,
    input  logic                 D,
    output logic [WIDTH_OUT-1:0] Q_bar,
    output logic                 GS_out_bar,
    output logic                 Change
);

    // Rise/fall delays describe the board-level part; the synthesizable core is zero-delay.
    if (WIDTH_OUT != (1 << WIDTH_IN) || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_cfg
        $error("ttl_priority_decoder_latch: WIDTH_OUT must be 2**WIDTH_IN, delays non-negative");
    end

    typedef enum logic [1:0] {
        ModeHold   = 2'b00,
        ModeLatch  = 2'b01,
        ModeDemux  = 2'b10,
        ModeDecode = 2'b11
    } mode_e;

    logic [WIDTH_OUT-1:0] q_q, q_d;
    logic                 change_q, change_d;
    logic [WIDTH_IN-1:0]  addr;
    logic [WIDTH_OUT-1:0] onehot;
    logic [WIDTH_OUT-1:0] decode_val;
    logic                 decode_take;

`ifdef TTL_DECODER_GLITCH_FILTER_EN
    logic [WIDTH_IN:0] pend_q, pend_d;
    logic              pend_valid_q, pend_valid_d;
`endif

    always_comb begin
        addr         = ~Y_bar;
        onehot       = '0;
        onehot[addr] = 1'b1;
        decode_val   = GS_bar ? '0 : onehot;
    end

    always_comb begin
        q_d         = q_q;
        decode_take = 1'b1;
`ifdef TTL_DECODER_GLITCH_FILTER_EN
        // Any edge that is not an enabled mode-11 edge breaks the agreement chain.
        pend_d       = pend_q;
        pend_valid_d = 1'b0;
        if (!EI_bar && mode_e'(Mode) == ModeDecode) begin
            decode_take  = pend_valid_q && (pend_q == {GS_bar, Y_bar});
            pend_d       = {GS_bar, Y_bar};
            pend_valid_d = 1'b1;
        end
`endif
        if (!EI_bar) begin
            unique case (mode_e'(Mode))
                ModeHold:   q_d = q_q;
                ModeLatch:  q_d[addr] = D;
                ModeDemux:  q_d = D ? onehot : '0;
                ModeDecode: q_d = decode_take ? decode_val : q_q;
            endcase
        end
        change_d = (q_d != q_q);
    end

    always_ff @(posedge Clk) begin
        if (!Clear_bar) begin
            q_q      <= '0;
            change_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            change_q <= change_d;
        end
    end

`ifdef TTL_DECODER_GLITCH_FILTER_EN
    always_ff @(posedge Clk) begin
        if (!Clear_bar) begin
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end
`endif

    assign Q_bar      = ~q_q;
    assign GS_out_bar = ~|q_q;
    assign Change     = change_q;

endmodule
